// File: rtl/decode_queue_pkg.sv
// Shared control-bundle encodings, ctrl field offsets and queue entry layout.
package decode_queue_pkg;

  localparam int DQ_CTRL_W = 29;

  // Bit offsets of each field inside the 29-bit ctrl bundle (LSB = div).
  localparam int DQ_DIV_OFF     = 0;
  localparam int DQ_MULS_OFF    = 1;
  localparam int DQ_HILO_OFF    = 2;
  localparam int DQ_SHAMT_OFF   = 6;
  localparam int DQ_BRJ_OFF     = 7;
  localparam int DQ_REGEN_OFF   = 10;
  localparam int DQ_M2R_OFF     = 11;
  localparam int DQ_MEMEN_OFF   = 14;
  localparam int DQ_ALUOP_OFF   = 18;
  localparam int DQ_ALUSRC_OFF  = 23;
  localparam int DQ_REGDST_OFF  = 25;
  localparam int DQ_BRANCH_OFF  = 27;

  localparam logic [1:0] BRANCH_PC4 = 2'd0, BRANCH_COND = 2'd1, BRANCH_J = 2'd2, BRANCH_JR = 2'd3;
  localparam logic [1:0] REGDST_RT = 2'd0, REGDST_RD = 2'd1, REGDST_RA = 2'd2;
  localparam logic [1:0] ALUSRC_REG = 2'd0, ALUSRC_IMM_S = 2'd1, ALUSRC_IMM_Z = 2'd2, ALUSRC_LUI = 2'd3;

  // ADD/SUB never trap; ADDT/SUBT are the overflow-trapping forms.
  localparam logic [4:0] ALUOP_NOP = 5'd0,  ALUOP_ADD = 5'd1,  ALUOP_ADDT = 5'd2, ALUOP_SUB = 5'd3,
                         ALUOP_SUBT = 5'd4, ALUOP_AND = 5'd5,  ALUOP_OR = 5'd6,   ALUOP_XOR = 5'd7,
                         ALUOP_NOR = 5'd8,  ALUOP_SLT = 5'd9,  ALUOP_SLTU = 5'd10, ALUOP_SLL = 5'd11,
                         ALUOP_SRL = 5'd12, ALUOP_SRA = 5'd13, ALUOP_LUI = 5'd14, ALUOP_MULT = 5'd15,
                         ALUOP_DIV = 5'd16;

  localparam logic [3:0] MEMEN_NONE = 4'd0, MEMEN_LB = 4'd1,  MEMEN_LBU = 4'd2, MEMEN_LH = 4'd3,
                         MEMEN_LHU = 4'd4,  MEMEN_LW = 4'd5,  MEMEN_LWL = 4'd6, MEMEN_LWR = 4'd7,
                         MEMEN_SB = 4'd8,   MEMEN_SH = 4'd9,  MEMEN_SW = 4'd10, MEMEN_SWL = 4'd11,
                         MEMEN_SWR = 4'd12;

  localparam logic [2:0] REG_FROM_ALU = 3'd0, REG_FROM_MEM = 3'd1, REG_FROM_HI = 3'd2,
                         REG_FROM_LO = 3'd3, REG_FROM_PC8 = 3'd4;

  localparam logic REGEN_N = 1'b0, REGEN_Y = 1'b1;

  localparam logic [2:0] BRJUDGE_NONE = 3'd0, BRJUDGE_EQ = 3'd1, BRJUDGE_NE = 3'd2, BRJUDGE_LEZ = 3'd3,
                         BRJUDGE_GTZ = 3'd4, BRJUDGE_LTZ = 3'd5, BRJUDGE_GEZ = 3'd6;

  localparam logic USE_SHAMT = 1'b1;

  // hilo_rwen = {hi_write, lo_write, hi_read, lo_read}
  localparam logic [3:0] HILO_NONE = 4'b0000, HILO_RD_LO = 4'b0001, HILO_RD_HI = 4'b0010,
                         HILO_WR_LO = 4'b0100, HILO_WR_HI = 4'b1000, HILO_WR_BOTH = 4'b1100;

  typedef struct packed {
    logic [31:0]          pc;
    logic [31:0]          inst;
    logic [DQ_CTRL_W-1:0] ctrl;
    logic                 ri;
    logic                 ds;
  } dq_entry_t;

endpackage

// File: rtl/decode_queue_lane.sv
// Combinational MIPS-I decoder for one fetch lane: ctrl bundle, reserved flag, branch flag.
module inst_decode_lane
  import decode_queue_pkg::*;
(
  input  logic [31:0]          inst,
  output logic [DQ_CTRL_W-1:0] ctrl,
  output logic                 ri,
  output logic                 is_branch
);

  logic [5:0] op, funct;
  logic [4:0] rt;
  logic [1:0] branch, regdst, alusrc;
  logic [4:0] aluop;
  logic [3:0] memen, hilo_rwen;
  logic [2:0] memtoreg, brjudge;
  logic       regen, shamt, mul_sign, div, known;
  logic       unused_fields;

  assign op            = inst[31:26];
  assign rt            = inst[20:16];
  assign funct         = inst[5:0];
  assign unused_fields = ^{inst[25:21], inst[15:6]};

  // Field decode; anything not matched clears known.
  always_comb begin
    branch = BRANCH_PC4; regdst = REGDST_RT; alusrc = ALUSRC_REG; aluop = ALUOP_NOP;
    memen = MEMEN_NONE; memtoreg = REG_FROM_ALU; regen = REGEN_N; brjudge = BRJUDGE_NONE;
    shamt = 1'b0; hilo_rwen = HILO_NONE; mul_sign = 1'b0; div = 1'b0; known = 1'b1;
    case (op)
      6'h00: begin
        regdst = REGDST_RD; regen = REGEN_Y;
        case (funct)
          6'h00: begin aluop = ALUOP_SLL; shamt = USE_SHAMT; end
          6'h02: begin aluop = ALUOP_SRL; shamt = USE_SHAMT; end
          6'h03: begin aluop = ALUOP_SRA; shamt = USE_SHAMT; end
          6'h04: aluop = ALUOP_SLL;
          6'h06: aluop = ALUOP_SRL;
          6'h07: aluop = ALUOP_SRA;
          6'h08: begin branch = BRANCH_JR; regen = REGEN_N; end
          6'h09: begin branch = BRANCH_JR; memtoreg = REG_FROM_PC8; end
          6'h0C: regen = REGEN_N;
          6'h10: begin memtoreg = REG_FROM_HI; hilo_rwen = HILO_RD_HI; end
          6'h11: begin regen = REGEN_N; hilo_rwen = HILO_WR_HI; end
          6'h12: begin memtoreg = REG_FROM_LO; hilo_rwen = HILO_RD_LO; end
          6'h13: begin regen = REGEN_N; hilo_rwen = HILO_WR_LO; end
          6'h18: begin regen = REGEN_N; aluop = ALUOP_MULT; hilo_rwen = HILO_WR_BOTH; mul_sign = 1'b1; end
          6'h19: begin regen = REGEN_N; aluop = ALUOP_MULT; hilo_rwen = HILO_WR_BOTH; end
          6'h1A: begin regen = REGEN_N; aluop = ALUOP_DIV; hilo_rwen = HILO_WR_BOTH; mul_sign = 1'b1; div = 1'b1; end
          6'h1B: begin regen = REGEN_N; aluop = ALUOP_DIV; hilo_rwen = HILO_WR_BOTH; div = 1'b1; end
          6'h20: aluop = ALUOP_ADDT;
          6'h21: aluop = ALUOP_ADD;
          6'h22: aluop = ALUOP_SUBT;
          6'h23: aluop = ALUOP_SUB;
          6'h24: aluop = ALUOP_AND;
          6'h25: aluop = ALUOP_OR;
          6'h26: aluop = ALUOP_XOR;
          6'h27: aluop = ALUOP_NOR;
          6'h2A: aluop = ALUOP_SLT;
          6'h2B: aluop = ALUOP_SLTU;
          default: known = 1'b0;
        endcase
      end
      6'h01: begin
        branch = BRANCH_COND;
        case (rt)
          5'h00, 5'h10: brjudge = BRJUDGE_LTZ;
          5'h01, 5'h11: brjudge = BRJUDGE_GEZ;
          default:      known = 1'b0;
        endcase
        if (rt[4]) begin regen = REGEN_Y; regdst = REGDST_RA; memtoreg = REG_FROM_PC8; end
      end
      6'h02: branch = BRANCH_J;
      6'h03: begin branch = BRANCH_J; regdst = REGDST_RA; memtoreg = REG_FROM_PC8; regen = REGEN_Y; end
      6'h04: begin branch = BRANCH_COND; brjudge = BRJUDGE_EQ; end
      6'h05: begin branch = BRANCH_COND; brjudge = BRJUDGE_NE; end
      6'h06: begin branch = BRANCH_COND; brjudge = BRJUDGE_LEZ; end
      6'h07: begin branch = BRANCH_COND; brjudge = BRJUDGE_GTZ; end
      6'h08: begin regen = REGEN_Y; alusrc = ALUSRC_IMM_S; aluop = ALUOP_ADDT; end
      6'h09: begin regen = REGEN_Y; alusrc = ALUSRC_IMM_S; aluop = ALUOP_ADD; end
      6'h0A: begin regen = REGEN_Y; alusrc = ALUSRC_IMM_S; aluop = ALUOP_SLT; end
      6'h0B: begin regen = REGEN_Y; alusrc = ALUSRC_IMM_S; aluop = ALUOP_SLTU; end
      6'h0C: begin regen = REGEN_Y; alusrc = ALUSRC_IMM_Z; aluop = ALUOP_AND; end
      6'h0D: begin regen = REGEN_Y; alusrc = ALUSRC_IMM_Z; aluop = ALUOP_OR; end
      6'h0E: begin regen = REGEN_Y; alusrc = ALUSRC_IMM_Z; aluop = ALUOP_XOR; end
      6'h0F: begin regen = REGEN_Y; alusrc = ALUSRC_LUI; aluop = ALUOP_LUI; end
      6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26: begin
        regen = REGEN_Y; alusrc = ALUSRC_IMM_S; aluop = ALUOP_ADD; memtoreg = REG_FROM_MEM;
        case (op[2:0])
          3'd0:    memen = MEMEN_LB;
          3'd1:    memen = MEMEN_LH;
          3'd2:    memen = MEMEN_LWL;
          3'd3:    memen = MEMEN_LW;
          3'd4:    memen = MEMEN_LBU;
          3'd5:    memen = MEMEN_LHU;
          default: memen = MEMEN_LWR;
        endcase
      end
      6'h28, 6'h29, 6'h2A, 6'h2B, 6'h2E: begin
        alusrc = ALUSRC_IMM_S; aluop = ALUOP_ADD;
        case (op[2:0])
          3'd0:    memen = MEMEN_SB;
          3'd1:    memen = MEMEN_SH;
          3'd2:    memen = MEMEN_SWL;
          3'd3:    memen = MEMEN_SW;
          default: memen = MEMEN_SWR;
        endcase
      end
      default: known = 1'b0;
    endcase
  end

  assign ri        = ~known;
  assign is_branch = known && (branch != BRANCH_PC4);

  // Pack the bundle; reserved encodings lose every side effect but keep the rest.
  always_comb begin
    ctrl = '0;
    ctrl[DQ_BRANCH_OFF +: 2] = ri ? BRANCH_PC4 : branch;
    ctrl[DQ_REGDST_OFF +: 2] = regdst;
    ctrl[DQ_ALUSRC_OFF +: 2] = alusrc;
    ctrl[DQ_ALUOP_OFF +: 5]  = aluop;
    ctrl[DQ_MEMEN_OFF +: 4]  = ri ? MEMEN_NONE : memen;
    ctrl[DQ_M2R_OFF +: 3]    = memtoreg;
    ctrl[DQ_REGEN_OFF]       = regen & ~ri;
    ctrl[DQ_BRJ_OFF +: 3]    = brjudge;
    ctrl[DQ_SHAMT_OFF]       = shamt;
    ctrl[DQ_HILO_OFF +: 4]   = ri ? HILO_NONE : hilo_rwen;
    ctrl[DQ_MULS_OFF]        = mul_sign;
    ctrl[DQ_DIV_OFF]         = div;
  end

endmodule

// File: rtl/decode_queue.sv
// Decode-and-buffer stage: decodes up to FETCH_W lanes per beat into a circular queue drained one per cycle.
module decode_queue
  import decode_queue_pkg::*;
#(
  parameter int FETCH_W = 2,
  parameter int DEPTH   = 8,
  parameter int CNT_W   = $clog2(DEPTH + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [FETCH_W-1:0]     in_mask,
  input  logic [31:0]            in_pc,
  input  logic [32*FETCH_W-1:0]  in_inst,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [31:0]            out_pc,
  output logic [31:0]            out_inst,
  output logic [DQ_CTRL_W-1:0]   out_ctrl,
  output logic                   out_ri,
  output logic                   out_ds,
  output logic [CNT_W-1:0]       count
);

  localparam int PTR_W = $clog2(DEPTH);

  dq_entry_t            mem [DEPTH];
  dq_entry_t            lane_entry [FETCH_W];
  dq_entry_t            head;
  logic [DQ_CTRL_W-1:0] lane_ctrl [FETCH_W];
  logic [FETCH_W-1:0]   lane_ri, lane_br, lane_we;
  logic [PTR_W-1:0]     wr_ptr, rd_ptr;
  logic [CNT_W-1:0]     num_push;
  logic                 tracker, push, pop, last_br, lane_run;

  for (genvar g = 0; g < FETCH_W; g++) begin : g_lane
    inst_decode_lane u_dec (
      .inst      (in_inst[32*g +: 32]),
      .ctrl      (lane_ctrl[g]),
      .ri        (lane_ri[g]),
      .is_branch (lane_br[g])
    );
  end

  assign in_ready  = (CNT_W'(DEPTH) - count) >= CNT_W'(FETCH_W);
  assign out_valid = (count != '0);
  assign push      = in_valid && in_ready && in_mask[0] && !flush;
  assign pop       = out_valid && out_ready && !flush;

  // Leading-ones lane enables, per-lane entries and the branch status of the last lane written.
  always_comb begin
    lane_we  = '0;
    num_push = '0;
    last_br  = tracker;
    lane_run = push;
    for (int i = 0; i < FETCH_W; i++) begin
      lane_run             = lane_run && in_mask[i];
      lane_we[i]           = lane_run;
      lane_entry[i].pc     = in_pc + 32'(4 * i);
      lane_entry[i].inst   = in_inst[32*i +: 32];
      lane_entry[i].ctrl   = lane_ctrl[i];
      lane_entry[i].ri     = lane_ri[i];
      lane_entry[i].ds     = (i == 0) ? tracker : lane_br[(i == 0) ? 0 : i - 1];
      if (lane_run) begin
        num_push = num_push + CNT_W'(1);
        last_br  = lane_br[i];
      end
    end
  end

  // Pointers, occupancy and delay-slot tracker; flush wins over push and pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      tracker <= 1'b0;
    end else if (flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      tracker <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr  <= wr_ptr + PTR_W'(num_push);
        tracker <= last_br;
      end
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + num_push - CNT_W'(pop);
    end
  end

  // Entry storage; only enabled lanes are written, at consecutive slots from wr_ptr.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      for (int i = 0; i < FETCH_W; i++)
        if (lane_we[i]) mem[wr_ptr + PTR_W'(i)] <= lane_entry[i];
    end
  end

  assign head     = mem[rd_ptr];
  assign out_pc   = head.pc;
  assign out_inst = head.inst;
  assign out_ctrl = head.ctrl;
  assign out_ri   = head.ri;
  assign out_ds   = head.ds;

endmodule

// File: tb/tb_decode_queue.sv
// Scoreboard bench for decode_queue: expected entries queued on push, compared on pop.
module tb_decode_queue;
  import decode_queue_pkg::*;

  localparam int FETCH_W = 2;
  localparam int DEPTH   = 8;
  localparam int CNT_W   = 4;

  localparam logic [31:0] I_ADDU  = 32'h00221821;
  localparam logic [31:0] I_LW    = 32'h8C240008;
  localparam logic [31:0] I_BEQ   = 32'h10220004;
  localparam logic [31:0] I_ADDIU = 32'h24250001;
  localparam logic [31:0] I_SW    = 32'hAC24000C;
  localparam logic [31:0] I_SLL   = 32'h000230C0;
  localparam logic [31:0] I_MULT  = 32'h00220018;
  localparam logic [31:0] I_JAL   = 32'h0C000040;
  localparam logic [31:0] I_RSV   = 32'hFC000000;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [28:0] ctrl;
    logic        ri;
    logic        ds;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_ready, out_valid, out_ready, out_ri, out_ds;
  logic [1:0]  in_mask;
  logic [31:0] in_pc, out_pc, out_inst;
  logic [63:0] in_inst;
  logic [28:0] out_ctrl;
  logic [CNT_W-1:0] count;

  exp_t        sb[$];
  logic        trk = 1'b0;
  int          checks = 0;
  int          failures = 0;
  logic [31:0] pool [9];

  decode_queue #(.FETCH_W(FETCH_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_mask(in_mask), .in_pc(in_pc), .in_inst(in_inst), .out_valid(out_valid),
    .out_ready(out_ready), .out_pc(out_pc), .out_inst(out_inst), .out_ctrl(out_ctrl),
    .out_ri(out_ri), .out_ds(out_ds), .count(count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [28:0] pack(input logic [1:0] br, input logic [1:0] rd, input logic [1:0] src,
                                       input logic [4:0] op, input logic [3:0] me, input logic [2:0] m2r,
                                       input logic re, input logic [2:0] bj, input logic sh,
                                       input logic [3:0] hl, input logic ms, input logic dv);
    return {br, rd, src, op, me, m2r, re, bj, sh, hl, ms, dv};
  endfunction

  function automatic logic [28:0] exp_ctrl(input logic [31:0] inst);
    case (inst)
      I_ADDU:  return pack(BRANCH_PC4, REGDST_RD, ALUSRC_REG, ALUOP_ADD, MEMEN_NONE, REG_FROM_ALU, 1'b1, BRJUDGE_NONE, 1'b0, HILO_NONE, 1'b0, 1'b0);
      I_LW:    return pack(BRANCH_PC4, REGDST_RT, ALUSRC_IMM_S, ALUOP_ADD, MEMEN_LW, REG_FROM_MEM, 1'b1, BRJUDGE_NONE, 1'b0, HILO_NONE, 1'b0, 1'b0);
      I_BEQ:   return pack(BRANCH_COND, REGDST_RT, ALUSRC_REG, ALUOP_NOP, MEMEN_NONE, REG_FROM_ALU, 1'b0, BRJUDGE_EQ, 1'b0, HILO_NONE, 1'b0, 1'b0);
      I_ADDIU: return pack(BRANCH_PC4, REGDST_RT, ALUSRC_IMM_S, ALUOP_ADD, MEMEN_NONE, REG_FROM_ALU, 1'b1, BRJUDGE_NONE, 1'b0, HILO_NONE, 1'b0, 1'b0);
      I_SW:    return pack(BRANCH_PC4, REGDST_RT, ALUSRC_IMM_S, ALUOP_ADD, MEMEN_SW, REG_FROM_ALU, 1'b0, BRJUDGE_NONE, 1'b0, HILO_NONE, 1'b0, 1'b0);
      I_SLL:   return pack(BRANCH_PC4, REGDST_RD, ALUSRC_REG, ALUOP_SLL, MEMEN_NONE, REG_FROM_ALU, 1'b1, BRJUDGE_NONE, 1'b1, HILO_NONE, 1'b0, 1'b0);
      I_MULT:  return pack(BRANCH_PC4, REGDST_RD, ALUSRC_REG, ALUOP_MULT, MEMEN_NONE, REG_FROM_ALU, 1'b0, BRJUDGE_NONE, 1'b0, HILO_WR_BOTH, 1'b1, 1'b0);
      I_JAL:   return pack(BRANCH_J, REGDST_RA, ALUSRC_REG, ALUOP_NOP, MEMEN_NONE, REG_FROM_PC8, 1'b1, BRJUDGE_NONE, 1'b0, HILO_NONE, 1'b0, 1'b0);
      default: return '0;
    endcase
  endfunction

  function automatic logic is_br(input logic [31:0] inst);
    return (inst == I_BEQ) || (inst == I_JAL);
  endfunction

  task automatic drive(input logic v, input logic [1:0] m, input logic [31:0] pc, input logic [31:0] i0,
                       input logic [31:0] i1, input logic ordy, input logic fl);
    in_valid = v; in_mask = m; in_pc = pc; in_inst = {i1, i0}; out_ready = ordy; flush = fl;
  endtask

  // One clock: sample at the falling edge, update the model, return just after the rising edge.
  task automatic step();
    int          sz;
    exp_t        e;
    logic [31:0] li;
    logic        prev_br;
    @(negedge clk);
    sz = sb.size();
    check("count", 64'(count), 64'(sz));
    check("out_valid", 64'(out_valid), 64'(sz != 0));
    check("in_ready", 64'(in_ready), 64'((DEPTH - sz) >= FETCH_W));
    if (flush) begin
      sb.delete();
      trk = 1'b0;
    end else begin
      if (out_ready && sz != 0) begin
        e = sb.pop_front();
        check("head_pc", 64'(out_pc), 64'(e.pc));
        check("head_inst", 64'(out_inst), 64'(e.inst));
        check("head_ctrl", 64'(out_ctrl), 64'(e.ctrl));
        check("head_ri", 64'(out_ri), 64'(e.ri));
        check("head_ds", 64'(out_ds), 64'(e.ds));
      end
      if (in_valid && in_mask[0] && (DEPTH - sz) >= FETCH_W) begin
        prev_br = trk;
        for (int i = 0; i < FETCH_W; i++) begin
          if (!in_mask[i]) break;
          li     = in_inst[32*i +: 32];
          e.pc   = in_pc + 32'(4 * i);
          e.inst = li;
          e.ctrl = exp_ctrl(li);
          e.ri   = (li == I_RSV);
          e.ds   = prev_br;
          sb.push_back(e);
          prev_br = is_br(li);
        end
        trk = prev_br;
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    pool = '{I_ADDU, I_LW, I_BEQ, I_ADDIU, I_SW, I_SLL, I_MULT, I_JAL, I_RSV};
    rst = 1'b1;
    drive(1'b0, 2'b00, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    check("rst_count", 64'(count), 64'(0));
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_in_ready", 64'(in_ready), 64'(1));
    check("rst_out_pc", 64'(out_pc), 64'(0));
    check("rst_out_inst", 64'(out_inst), 64'(0));
    check("rst_out_ctrl", 64'(out_ctrl), 64'(0));
    check("rst_out_ri", 64'(out_ri), 64'(0));
    check("rst_out_ds", 64'(out_ds), 64'(0));
    rst = 1'b0;

    // Two-lane beat {addu, lw}
    drive(1'b1, 2'b11, 32'h1000, I_ADDU, I_LW, 1'b0, 1'b0); step();
    drive(1'b0, 2'b00, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    check("t1_valid", 64'(out_valid), 64'(1));
    check("t1_count", 64'(count), 64'(2));
    check("t1_pc", 64'(out_pc), 64'(32'h1000));
    check("t1_aluop", 64'(out_ctrl[DQ_ALUOP_OFF +: 5]), 64'(ALUOP_ADD));
    check("t1_regdst", 64'(out_ctrl[DQ_REGDST_OFF +: 2]), 64'(REGDST_RD));
    drive(1'b0, 2'b00, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0); step();
    check("t1_pc2", 64'(out_pc), 64'(32'h1004));
    check("t1_memtoreg", 64'(out_ctrl[DQ_M2R_OFF +: 3]), 64'(REG_FROM_MEM));
    step();
    step();

    // Delay slot across beats
    drive(1'b1, 2'b11, 32'h2000, I_ADDU, I_BEQ, 1'b0, 1'b0); step();
    drive(1'b1, 2'b01, 32'h2008, I_ADDIU, 32'h0, 1'b0, 1'b0); step();
    drive(1'b0, 2'b00, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0); step();
    check("t2_beq_ds", 64'(out_ds), 64'(0));
    step();
    check("t2_addiu_ds", 64'(out_ds), 64'(1));
    check("t2_addiu_inst", 64'(out_inst), 64'(I_ADDIU));
    step();

    // Reserved encoding
    drive(1'b1, 2'b01, 32'h3000, I_RSV, 32'h0, 1'b0, 1'b0); step();
    check("t3_ri", 64'(out_ri), 64'(1));
    check("t3_regen", 64'(out_ctrl[DQ_REGEN_OFF]), 64'(0));
    check("t3_memen", 64'(out_ctrl[DQ_MEMEN_OFF +: 4]), 64'(MEMEN_NONE));
    check("t3_hilo", 64'(out_ctrl[DQ_HILO_OFF +: 4]), 64'(HILO_NONE));
    check("t3_branch", 64'(out_ctrl[DQ_BRANCH_OFF +: 2]), 64'(BRANCH_PC4));
    drive(1'b0, 2'b00, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0); step();

    // Fill to full, then pop with a blocked push
    for (int b = 0; b < 4; b++) begin
      drive(1'b1, 2'b11, 32'h4000 + 32'(8 * b), I_SW, I_SLL, 1'b0, 1'b0); step();
    end
    check("t4_full_count", 64'(count), 64'(8));
    check("t4_full_ready", 64'(in_ready), 64'(0));
    drive(1'b1, 2'b11, 32'h5000, I_ADDU, I_LW, 1'b1, 1'b0); step();
    check("t4_count7", 64'(count), 64'(7));
    check("t4_ready7", 64'(in_ready), 64'(0));
    drive(1'b0, 2'b00, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0);
    repeat (7) step();

    // Flush with simultaneous push and pop, tracker set beforehand
    drive(1'b1, 2'b11, 32'h6000, I_ADDU, I_LW, 1'b0, 1'b0); step();
    drive(1'b1, 2'b11, 32'h6008, I_SW, I_MULT, 1'b0, 1'b0); step();
    drive(1'b1, 2'b01, 32'h6010, I_BEQ, 32'h0, 1'b0, 1'b0); step();
    check("t5_count5", 64'(count), 64'(5));
    drive(1'b1, 2'b11, 32'h7000, I_ADDU, I_ADDU, 1'b1, 1'b1); step();
    drive(1'b0, 2'b00, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    check("t5_flush_count", 64'(count), 64'(0));
    check("t5_flush_valid", 64'(out_valid), 64'(0));
    drive(1'b1, 2'b01, 32'h7100, I_ADDIU, 32'h0, 1'b0, 1'b0); step();
    check("t5_ds_cleared", 64'(out_ds), 64'(0));
    drive(1'b0, 2'b00, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0); step();

    // Random beats and random back-pressure across pointer wrap
    for (int n = 0; n < 20; n++) begin
      drive(1'b1, 2'($urandom_range(0, 3)), 32'h8000 + 32'(8 * n),
            pool[$urandom_range(0, 8)], pool[$urandom_range(0, 8)],
            1'($urandom_range(0, 1)), 1'b0);
      step();
    end
    drive(1'b0, 2'b00, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0);
    for (int k = 0; k < 40 && sb.size() != 0; k++) step();
    check("t6_drained", 64'(count), 64'(0));

    // Asynchronous reset mid-burst
    drive(1'b1, 2'b11, 32'h9000, I_ADDU, I_BEQ, 1'b0, 1'b0); step();
    drive(1'b0, 2'b00, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    #3 rst = 1'b1;
    #1;
    check("t7_count", 64'(count), 64'(0));
    check("t7_valid", 64'(out_valid), 64'(0));
    check("t7_ready", 64'(in_ready), 64'(1));
    check("t7_pc", 64'(out_pc), 64'(0));
    check("t7_ctrl", 64'(out_ctrl), 64'(0));
    sb.delete();
    trk = 1'b0;
    #2 rst = 1'b0;
    @(posedge clk);
    #1;
    drive(1'b1, 2'b01, 32'h9100, I_JAL, 32'h0, 1'b0, 1'b0); step();
    check("t7_ds_after_rst", 64'(out_ds), 64'(0));
    drive(1'b0, 2'b00, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0); step();
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
